// File: rtl/debouncer_array.sv
// Per-channel switch debouncer: 2-flop sync, symmetric stability
// counter, press/release pulses and optional auto-repeat.
module debouncer_array #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1048576,
  parameter int REPEAT_CYCLES = 0,
  parameter int CNT_W         = 21
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] trigger,
  output logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam logic [CNT_W-1:0] S_LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic [CHANNELS-1:0] meta;
  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] diff;
  logic [CHANNELS-1:0] flip;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= trigger;
      sync <= meta;
    end
  end

  assign diff = sync ^ button;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;

    assign flip[i] = diff[i] & (cnt == S_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt <= '0;
      else if (!diff[i] || flip[i])
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  assign rise = flip & sync;
  assign fall = flip & ~sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button        <= '0;
      press         <= '0;
      release_pulse <= '0;
    end else begin
      button        <= button ^ flip;
      press         <= rise;
      release_pulse <= fall;
    end
  end

  if (REPEAT_CYCLES > 0) begin : g_rpt
    localparam logic [CNT_W-1:0] R_LAST =
      CNT_W'(REPEAT_CYCLES - 1);

    logic [CHANNELS-1:0] hit;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_W-1:0] rcnt;

      // a repeat due on the release edge is dropped
      assign hit[i] = button[i] & ~fall[i] &
                      (rcnt == R_LAST);

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          rcnt <= '0;
        else if (!button[i] || fall[i] || hit[i])
          rcnt <= '0;
        else
          rcnt <= rcnt + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        repeat_pulse <= '0;
      else
        repeat_pulse <= hit;
    end
  end else begin : g_no_rpt
    assign repeat_pulse = '0;
  end

endmodule

// File: tb/tb_debouncer_array.sv
// Directed bench for debouncer_array with
// CHANNELS=4, STABLE_CYCLES=4, REPEAT_CYCLES=8.
module tb_debouncer_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] trigger = 4'b0000;
  logic [3:0] button;
  logic [3:0] press;
  logic [3:0] rel;
  logic [3:0] rpt;

  int checks = 0;
  int errors = 0;

  debouncer_array #(
    .CHANNELS(4),
    .STABLE_CYCLES(4),
    .REPEAT_CYCLES(8),
    .CNT_W(21)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .button(button),
    .press(press),
    .release_pulse(rel),
    .repeat_pulse(rpt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag,
                            input logic [3:0] b,
                            input logic [3:0] p,
                            input logic [3:0] r,
                            input logic [3:0] t);
    chk({tag, " button"}, button, b);
    chk({tag, " press"}, press, p);
    chk({tag, " release"}, rel, r);
    chk({tag, " repeat"}, rpt, t);
  endtask

  initial begin
    logic [3:0] eb, ep, er, et;

    // reset state
    tick();
    tick();
    expect_out("reset", 4'b0000, 4'b0000,
               4'b0000, 4'b0000);

    // clean step on channel 0
    rst = 1'b0;
    trigger = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      eb = (e >= 6) ? 4'b0001 : 4'b0000;
      ep = (e == 6) ? 4'b0001 : 4'b0000;
      expect_out($sformatf("step e%0d", e),
                 eb, ep, 4'b0000, 4'b0000);
    end
    trigger = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      eb = (e < 6) ? 4'b0001 : 4'b0000;
      er = (e == 6) ? 4'b0001 : 4'b0000;
      expect_out($sformatf("step_rel e%0d", e),
                 eb, 4'b0000, er, 4'b0000);
    end

    // 3-cycle glitch on channel 1
    trigger = 4'b0010;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) trigger = 4'b0000;
      tick();
      expect_out($sformatf("glitch e%0d", e),
                 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // bounce 1,0,1,0,1 then hold on channel 2
    for (int e = 1; e <= 11; e++) begin
      if (e <= 5)
        trigger = (e % 2 == 1) ? 4'b0100 : 4'b0000;
      else
        trigger = 4'b0100;
      tick();
      eb = (e >= 10) ? 4'b0100 : 4'b0000;
      ep = (e == 10) ? 4'b0100 : 4'b0000;
      expect_out($sformatf("bounce e%0d", e),
                 eb, ep, 4'b0000, 4'b0000);
    end
    trigger = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      eb = (e < 6) ? 4'b0100 : 4'b0000;
      er = (e == 6) ? 4'b0100 : 4'b0000;
      expect_out($sformatf("bounce_rel e%0d", e),
                 eb, 4'b0000, er, 4'b0000);
    end

    // 40-cycle hold with auto-repeat on channel 0
    for (int e = 1; e <= 50; e++) begin
      if (e == 1) trigger = 4'b0001;
      if (e == 41) trigger = 4'b0000;
      tick();
      eb = (e >= 6 && e < 46) ? 4'b0001 : 4'b0000;
      ep = (e == 6) ? 4'b0001 : 4'b0000;
      er = (e == 46) ? 4'b0001 : 4'b0000;
      et = (e == 14 || e == 22 || e == 30 || e == 38)
           ? 4'b0001 : 4'b0000;
      expect_out($sformatf("hold e%0d", e),
                 eb, ep, er, et);
    end

    // reset mid-count: ch0 pressed, ch3 counter at 2
    trigger = 4'b0001;
    for (int e = 1; e <= 6; e++) tick();
    expect_out("pre_rst press", 4'b0001, 4'b0001,
               4'b0000, 4'b0000);
    trigger = 4'b1001;
    for (int e = 1; e <= 4; e++) tick();
    expect_out("pre_rst hold", 4'b0001, 4'b0000,
               4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    expect_out("rst async", 4'b0000, 4'b0000,
               4'b0000, 4'b0000);
    tick();
    expect_out("rst held", 4'b0000, 4'b0000,
               4'b0000, 4'b0000);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      eb = (e >= 6) ? 4'b1001 : 4'b0000;
      ep = (e == 6) ? 4'b1001 : 4'b0000;
      expect_out($sformatf("post_rst e%0d", e),
                 eb, ep, 4'b0000, 4'b0000);
    end
    trigger = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      eb = (e < 6) ? 4'b1001 : 4'b0000;
      er = (e == 6) ? 4'b1001 : 4'b0000;
      expect_out($sformatf("post_rst_rel e%0d", e),
                 eb, 4'b0000, er, 4'b0000);
    end

    // all channels together, staggered releases
    trigger = 4'b1111;
    for (int e = 1; e <= 6; e++) begin
      tick();
      eb = (e >= 6) ? 4'b1111 : 4'b0000;
      ep = (e == 6) ? 4'b1111 : 4'b0000;
      expect_out($sformatf("simul e%0d", e),
                 eb, ep, 4'b0000, 4'b0000);
    end
    for (int k = 1; k <= 16; k++) begin
      for (int i = 0; i < 4; i++)
        if (k == 1 + 2 * i) trigger[i] = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
        eb[i] = (k < 6 + 2 * i);
        er[i] = (k == 6 + 2 * i);
        et[i] = (k == 8) && (8 < 6 + 2 * i);
      end
      expect_out($sformatf("simul_rel k%0d", k),
                 eb, 4'b0000, er, et);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
